medidor_frecuencia: RTL and testbench

- Gated frequency meter for the 50 MHz board oscillator domain.
- Counts rising edges of an asynchronous external signal over a fixed gate window of GATE_CYCLES system clocks (1 s by default) and reports the count in Hz.
- Serves as the measuring counterpart to the team's clock dividers; used to check divided or external clocks on the board and drive display blocks.

---
 rtl/medidor_frecuencia.sv | 145 ++++++++++++++
 tb/tb_medidor_frecuencia.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: gated frequency meter; counts rising edges of senal_Entrada over GATE_CYCLES clocks.
// Define MEDIDOR_PERIODO_EN to add the edge-to-edge period outputs (periodo, periodo_valido).
module medidor_frecuencia #(
    parameter int GATE_CYCLES   = 50000000,
    parameter int CNT_W         = 27,
    parameter int MODO_CONTINUO = 1
) (
    input  logic             clk_Entrada,
    input  logic             rst,
    input  logic             senal_Entrada,
    input  logic             inicio,
    output logic [CNT_W-1:0] frecuencia,
    output logic             valido,
    output logic             ocupado,
    output logic             desborde
`ifdef MEDIDOR_PERIODO_EN
    ,
    output logic [CNT_W-1:0] periodo,
    output logic             periodo_valido
`endif
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        REPOSO   = 1'b0,
        MEDICION = 1'b1
    } estado_t;

    localparam estado_t ESTADO_RESET = (MODO_CONTINUO != 0) ? MEDICION : REPOSO;

    estado_t           estado, estado_sig;
    logic              sync_1, sync_2, prev;
    logic              flanco;
    logic              midiendo, terminal, arranque;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt, edge_cnt_sig;
    logic              sobre, sobre_sig;

    // Two-flop synchronizer plus history flop for the asynchronous input.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_Entrada) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_1 <= senal_Entrada;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign flanco = sync_2 & ~prev;

    always_ff @(posedge clk_Entrada) begin
        if (!rst) estado <= ESTADO_RESET;
        else      estado <= estado_sig;
    end

    // NOTE: defaulting every always_comb target first keeps the block free of inferred latches.
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:   if (inicio) estado_sig = MEDICION;
            MEDICION: if (terminal && MODO_CONTINUO == 0) estado_sig = REPOSO;
            default:  estado_sig = ESTADO_RESET;
        endcase
    end

    always_comb begin
        midiendo = (estado == MEDICION);
        terminal = midiendo && (gate_cnt == GATE_LAST);
        arranque = (estado == REPOSO) && inicio;
    end

    // Saturating edge count; an edge arriving while saturated marks the window as overflowed.
    always_comb begin
        edge_cnt_sig = edge_cnt;
        sobre_sig    = sobre;
        if (flanco) begin
            if (edge_cnt == CNT_MAX) sobre_sig    = 1'b1;
            else                     edge_cnt_sig = edge_cnt + CNT_W'(1);
        end
    end

    // ocupado is registered from the next state so it reads 0 while reset is held, even in continuous mode.
    always_ff @(posedge clk_Entrada) begin
        if (!rst) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sobre      <= 1'b0;
            frecuencia <= '0;
            desborde   <= 1'b0;
            valido     <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            valido  <= 1'b0;
            ocupado <= (estado_sig == MEDICION);
            if (arranque) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sobre    <= 1'b0;
            end else if (terminal) begin
                frecuencia <= edge_cnt_sig;
                desborde   <= sobre_sig;
                valido     <= 1'b1;
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                sobre      <= 1'b0;
            end else if (midiendo) begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                edge_cnt <= edge_cnt_sig;
                sobre    <= sobre_sig;
            end
        end
    end

`ifdef MEDIDOR_PERIODO_EN
    logic [CNT_W-1:0] per_cnt;
    logic             visto;

    // Free-running period counter: reloads to 1 on each edge so it holds the edge spacing at the next edge.
    always_ff @(posedge clk_Entrada) begin
        if (!rst) begin
            per_cnt        <= '0;
            visto          <= 1'b0;
            periodo        <= '0;
            periodo_valido <= 1'b0;
        end else begin
            periodo_valido <= flanco & visto;
            if (flanco) begin
                per_cnt <= CNT_W'(1);
                visto   <= 1'b1;
                if (visto) periodo <= per_cnt;
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_medidor_frecuencia.sv
// Directed bench for medidor_frecuencia: continuous, saturating (CNT_W=4) and single-shot instances.
`timescale 1ns/1ps
module tb_medidor_frecuencia;

    localparam int GATE = 100;
    localparam int WA   = 27;
    localparam int WB   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, sig_a, ini_a, v_a, o_a, d_a;
    logic [WA-1:0] f_a;
    logic          rst_b, sig_b, ini_b, v_b, o_b, d_b;
    logic [WB-1:0] f_b;
    logic          rst_c, sig_c, ini_c, v_c, o_c, d_c;
    logic [WA-1:0] f_c;
`ifdef MEDIDOR_PERIODO_EN
    logic [WA-1:0] p_a;
    logic          pv_a;
    logic [WB-1:0] p_b;
    logic          pv_b;
    logic [WA-1:0] p_c;
    logic          pv_c;
`endif

    medidor_frecuencia #(.GATE_CYCLES(GATE), .CNT_W(WA), .MODO_CONTINUO(1)) dut_a (
        .clk_Entrada(clk), .rst(rst_a), .senal_Entrada(sig_a), .inicio(ini_a),
        .frecuencia(f_a), .valido(v_a), .ocupado(o_a), .desborde(d_a)
`ifdef MEDIDOR_PERIODO_EN
        , .periodo(p_a), .periodo_valido(pv_a)
`endif
    );

    medidor_frecuencia #(.GATE_CYCLES(GATE), .CNT_W(WB), .MODO_CONTINUO(1)) dut_b (
        .clk_Entrada(clk), .rst(rst_b), .senal_Entrada(sig_b), .inicio(ini_b),
        .frecuencia(f_b), .valido(v_b), .ocupado(o_b), .desborde(d_b)
`ifdef MEDIDOR_PERIODO_EN
        , .periodo(p_b), .periodo_valido(pv_b)
`endif
    );

    medidor_frecuencia #(.GATE_CYCLES(GATE), .CNT_W(WA), .MODO_CONTINUO(0)) dut_c (
        .clk_Entrada(clk), .rst(rst_c), .senal_Entrada(sig_c), .inicio(ini_c),
        .frecuencia(f_c), .valido(v_c), .ocupado(o_c), .desborde(d_c)
`ifdef MEDIDOR_PERIODO_EN
        , .periodo(p_c), .periodo_valido(pv_c)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Square-wave generators: period 0 means hold the given level.
    int   per_a = 0, per_b = 4, per_c = 10;
    int   ph_a = 0, ph_b = 0, ph_c = 0;
    logic lvl_a = 1'b0, lvl_b = 1'b0, lvl_c = 1'b0;

    initial begin
        sig_a = 1'b0;
        sig_b = 1'b0;
        sig_c = 1'b0;
        forever begin
            @(negedge clk);
            sig_a = (per_a > 0) ? (ph_a < per_a / 2) : lvl_a;
            sig_b = (per_b > 0) ? (ph_b < per_b / 2) : lvl_b;
            sig_c = (per_c > 0) ? (ph_c < per_c / 2) : lvl_c;
            ph_a  = (per_a > 0) ? (ph_a + 1) % per_a : 0;
            ph_b  = (per_b > 0) ? (ph_b + 1) % per_b : 0;
            ph_c  = (per_c > 0) ? (ph_c + 1) % per_c : 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic vld(input int which);
        case (which)
            0:       return v_a;
            1:       return v_b;
            default: return v_c;
        endcase
    endfunction

    // Returns the number of negedges until valido is seen, or 0 if the budget expires.
    task automatic wait_valido(input int which, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!vld(which) && cycles < budget);
        if (!vld(which)) cycles = 0;
    endtask

`ifdef MEDIDOR_PERIODO_EN
    function automatic logic pvld(input int which);
        case (which)
            0:       return pv_a;
            1:       return pv_b;
            default: return pv_c;
        endcase
    endfunction

    task automatic wait_pv(input int which, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!pvld(which) && cycles < budget);
        if (!pvld(which)) cycles = 0;
    endtask
`endif

    initial begin
        int cyc;
        int nv;
        int no;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ini_a = 1'b0; ini_b = 1'b0; ini_c = 1'b0;
        repeat (3) @(negedge clk);
        check("a reset frecuencia", f_a, 0);
        check("a reset valido", v_a, 0);
        check("a reset ocupado", o_a, 0);
        check("a reset desborde", d_a, 0);
        check("c reset ocupado", o_c, 0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // Continuous mode, 10-clock period input.
        per_a = 10;
        wait_valido(0, 300, cyc);
        check("a first window seen", cyc != 0, 1);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            wait_valido(0, 300, cyc);
            check("a valido spacing", cyc + 1, GATE);
            check("a frecuencia", f_a, 10);
            check("a desborde", d_a, 0);
            check("a ocupado", o_a, 1);
            @(negedge clk);
            check("a valido single cycle", v_a, 0);
        end
        repeat (40) @(negedge clk);
        check("a frecuencia hold", f_a, 10);

        // Static input, low then high.
        per_a = 0;
        lvl_a = 1'b0;
        wait_valido(0, 300, cyc);
        for (int w = 0; w < 2; w++) begin
            wait_valido(0, 300, cyc);
            check("a static low spacing", cyc, GATE);
            check("a static low frecuencia", f_a, 0);
        end
        lvl_a = 1'b1;
        wait_valido(0, 300, cyc);
        for (int w = 0; w < 2; w++) begin
            wait_valido(0, 300, cyc);
            check("a static high frecuencia", f_a, 0);
        end

        // Reset in the middle of a window.
        per_a = 10;
        wait_valido(0, 300, cyc);
        wait_valido(0, 300, cyc);
        repeat (50) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        check("a midreset frecuencia", f_a, 0);
        check("a midreset valido", v_a, 0);
        check("a midreset ocupado", o_a, 0);
        check("a midreset desborde", d_a, 0);
        wait_valido(0, 300, cyc);
        check("a no valido for aborted window", cyc, GATE);
        wait_valido(0, 300, cyc);
        check("a next full window", f_a, 10);

`ifdef MEDIDOR_PERIODO_EN
        for (int k = 0; k < 3; k++) begin
            wait_pv(0, 50, cyc);
            check("a periodo_valido seen", cyc != 0, 1);
            check("a periodo", p_a, 10);
        end
`endif

        // Saturation with CNT_W=4: 25 edges per window.
        wait_valido(1, 300, cyc);
        wait_valido(1, 300, cyc);
        check("b sat spacing", cyc, GATE);
        check("b sat frecuencia", f_b, 15);
        check("b sat desborde", d_b, 1);
        per_b = 10;
        wait_valido(1, 300, cyc);
        wait_valido(1, 300, cyc);
        check("b recovered frecuencia", f_b, 10);
        check("b recovered desborde", d_b, 0);

`ifdef MEDIDOR_PERIODO_EN
        per_b = 0;
        lvl_b = 1'b0;
        repeat (4095 + 10) @(negedge clk);
        per_b = 10;
        wait_pv(1, 50, cyc);
        check("b stall periodo_valido seen", cyc != 0, 1);
        check("b stall periodo saturated", p_b, 15);
`endif

        // Single-shot mode: idle until inicio, extra inicio pulses ignored.
        nv = 0;
        no = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            nv += int'(v_c);
            no += int'(o_c);
        end
        check("c idle valido count", nv, 0);
        check("c idle ocupado count", no, 0);
        ini_c = 1'b1;
        @(negedge clk);
        ini_c = 1'b0;
        check("c ocupado rises", o_c, 1);
        cyc = 0;
        for (int k = 1; k <= 250 && cyc == 0; k++) begin
            @(negedge clk);
            ini_c = (k == 30 || k == 60);
            if (v_c) begin
                cyc = k;
                check("c ocupado drops with valido", o_c, 0);
            end
        end
        ini_c = 1'b0;
        check("c window length", cyc, GATE);
        check("c frecuencia", f_c, 10);
        check("c desborde", d_c, 0);
        nv = 0;
        no = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            nv += int'(v_c);
            no += int'(o_c);
        end
        check("c no further valido", nv, 0);
        check("c stays idle", no, 0);
        check("c frecuencia hold", f_c, 10);
`ifdef MEDIDOR_PERIODO_EN
        check("c periodo", p_c, 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
